// File: rtl/mem_bus_responder.sv
// mem_bus_responder: RAM-side endpoint for the data-side memory request bus.
// Serves one read (INCR beats) or one write burst at a time from an internal
// word-addressed memory. After every transaction it parks in DROP until the
// master releases its request, so a held request is never served twice.
module mem_bus_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned RD_LAT = 2,
   parameter logic [3:0]  RID    = 4'b0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_rdata,
   input  logic [3:0]  ram_wdata,
   input  logic [31:0] ram_addr_o,
   input  logic [31:0] ram_data_o,
   input  logic [3:0]  ram_arlen,
   input  logic [3:0]  ram_awlen,
   input  logic        ram_wvalid,
   input  logic        ram_wlast,
   output logic [3:0]  ram_rid,
   output logic        ram_rvalid,
   output logic        ram_rlast,
   output logic [31:0] ram_data_i,
   output logic        write_begin,
   output logic        ram_wready,
   output logic        ram_bvalid
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      R_WAIT = 3'd1,
      R_BEAT = 3'd2,
      W_DATA = 3'd3,
      W_RESP = 3'd4,
      DROP   = 3'd5
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [3:0]        len;
   logic [3:0]        beat;
   logic [3:0]        wstrb;
   logic [CNT_W-1:0]  lat_cnt;
   logic [31:0]       mem [DEPTH];

   logic              wr_fire;
   logic              wr_end;
   logic              unused_addr_bits;

   // Byte-offset and out-of-range address bits carry no meaning for a word memory.
   assign unused_addr_bits = ^{ram_addr_o[31:ADDR_W+2], ram_addr_o[1:0]};

   // A beat is taken whenever wvalid arrives in W_DATA; early wlast or the
   // awlen-th beat both close the burst.
   assign wr_fire = (state == W_DATA) && ram_wvalid;
   assign wr_end  = wr_fire && (ram_wlast || (beat == len));

   // Byte-masked memory write; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem[idx][8*b +: 8] <= ram_data_o[8*b +: 8];
            end
         end
      end
   end

   // Transaction FSM with registered handshake and read-data outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         idx         <= '0;
         len         <= '0;
         beat        <= '0;
         wstrb       <= '0;
         lat_cnt     <= '0;
         ram_rid     <= '0;
         ram_rvalid  <= 1'b0;
         ram_rlast   <= 1'b0;
         ram_data_i  <= '0;
         write_begin <= 1'b0;
         ram_wready  <= 1'b0;
         ram_bvalid  <= 1'b0;
      end else begin
         // pulse-type outputs fall back to zero unless a state drives them
         ram_rid     <= '0;
         ram_rvalid  <= 1'b0;
         ram_rlast   <= 1'b0;
         ram_data_i  <= '0;
         write_begin <= 1'b0;
         ram_bvalid  <= 1'b0;

         case (state)
            IDLE: begin
               beat <= '0;
               if (ram_rdata) begin
                  idx     <= ram_addr_o[ADDR_W+1:2];
                  len     <= ram_arlen;
                  lat_cnt <= CNT_W'(RD_LAT - 1);
                  state   <= R_WAIT;
               end else if (ram_wdata != 4'h0) begin
                  idx         <= ram_addr_o[ADDR_W+1:2];
                  len         <= ram_awlen;
                  wstrb       <= ram_wdata;
                  write_begin <= 1'b1;
                  ram_wready  <= 1'b1;
                  state       <= W_DATA;
               end
            end

            R_WAIT: begin
               if (lat_cnt == '0) begin
                  state <= R_BEAT;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end

            R_BEAT: begin
               ram_rvalid <= 1'b1;
               ram_rid    <= RID;
               ram_data_i <= mem[idx];
               ram_rlast  <= (beat == len);
               idx        <= idx + 1'b1;
               beat       <= beat + 1'b1;
               if (beat == len) begin
                  state <= DROP;
               end
            end

            W_DATA: begin
               if (wr_fire) begin
                  idx  <= idx + 1'b1;
                  beat <= beat + 1'b1;
               end
               if (wr_end) begin
                  ram_wready <= 1'b0;
                  ram_bvalid <= 1'b1;
                  state      <= W_RESP;
               end
            end

            W_RESP: begin
               state <= DROP;
            end

            DROP: begin
               if (!ram_rdata && (ram_wdata == 4'h0)) begin
                  state <= IDLE;
               end
            end

            default: begin
               ram_wready <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: randomized scoreboard bench for mem_bus_responder.
// Drivers push expected events (read beats, write_begin, bvalid) into a queue
// using a flat array model of memory; a monitor pops and compares them.
module tb_mem_bus_responder;

   localparam int         ADDR_W = 10;
   localparam int         RD_LAT = 2;
   localparam logic [3:0] RID    = 4'b0001;
   localparam int         DEPTH  = 1 << ADDR_W;

   localparam logic [1:0] EV_RD = 2'd0;
   localparam logic [1:0] EV_WB = 2'd1;
   localparam logic [1:0] EV_BR = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] data;
      logic        last;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        ram_rdata;
   logic [3:0]  ram_wdata;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_data_o;
   logic [3:0]  ram_arlen;
   logic [3:0]  ram_awlen;
   logic        ram_wvalid;
   logic        ram_wlast;
   logic [3:0]  ram_rid;
   logic        ram_rvalid;
   logic        ram_rlast;
   logic [31:0] ram_data_i;
   logic        write_begin;
   logic        ram_wready;
   logic        ram_bvalid;

   int          vectors;
   int          miscompares;
   ev_t         exp_q[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wbuf [16];

   mem_bus_responder #(
      .ADDR_W(ADDR_W),
      .RD_LAT(RD_LAT),
      .RID   (RID)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ram_rdata  (ram_rdata),
      .ram_wdata  (ram_wdata),
      .ram_addr_o (ram_addr_o),
      .ram_data_o (ram_data_o),
      .ram_arlen  (ram_arlen),
      .ram_awlen  (ram_awlen),
      .ram_wvalid (ram_wvalid),
      .ram_wlast  (ram_wlast),
      .ram_rid    (ram_rid),
      .ram_rvalid (ram_rvalid),
      .ram_rlast  (ram_rlast),
      .ram_data_i (ram_data_i),
      .write_begin(write_begin),
      .ram_wready (ram_wready),
      .ram_bvalid (ram_bvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // pop the next expected event and compare it against what the DUT shows
   task automatic expect_ev(input string name, input logic [1:0] kind,
                            input logic [31:0] data, input logic last);
      ev_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s unexpected: got event data %h, required no event", name, data);
      end else begin
         e = exp_q.pop_front();
         check({name, " kind"}, 32'(kind), 32'(e.kind));
         if (kind == EV_RD && e.kind == EV_RD) begin
            check({name, " data"}, data, e.data);
            check({name, " rlast"}, 32'(last), 32'(e.last));
         end
      end
   endtask

   // monitor: sample outputs mid-cycle and match them to the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (ram_rvalid) begin
            expect_ev("read beat", EV_RD, ram_data_i, ram_rlast);
            check("read rid", 32'(ram_rid), 32'(RID));
         end else begin
            check("idle rdata", ram_data_i, 32'h0);
            check("idle rid_rlast", {27'b0, ram_rlast, ram_rid}, 32'h0);
         end
         if (write_begin) expect_ev("write_begin", EV_WB, 32'h0, 1'b0);
         if (ram_bvalid)  expect_ev("bvalid", EV_BR, 32'h0, 1'b0);
      end
   end

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      check({name, " drain"}, 32'(exp_q.size()), 32'h0);
   endtask

   task automatic push_ev(input logic [1:0] kind, input logic [31:0] data, input logic last);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic read_txn(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] hold_w);
      int start;
      int lat;
      start = int'((addr >> 2) % DEPTH);
      for (int i = 0; i <= int'(len); i++)
         push_ev(EV_RD, ref_mem[(start + i) % DEPTH], (i == int'(len)));
      @(negedge clk);
      ram_rdata  = 1'b1;
      ram_wdata  = hold_w;
      ram_addr_o = addr;
      ram_arlen  = len;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ram_rvalid && lat < 20);
      check("read latency", 32'(lat), 32'(RD_LAT + 1));
      wait_drain("read");
      repeat (3) @(posedge clk);
      @(negedge clk);
      ram_rdata = 1'b0;
      ram_wdata = 4'h0;
      ram_arlen = 4'h0;
      repeat (2) @(negedge clk);
   endtask

   // wl: beat index carrying wlast, or -1 for a burst with no wlast at all
   task automatic write_txn(input logic [31:0] addr, input logic [3:0] len,
                            input logic [3:0] strb, input int wl);
      int start;
      int n;
      int w;
      int cnt;
      start = int'((addr >> 2) % DEPTH);
      n = (wl >= 0 && wl <= int'(len)) ? wl + 1 : int'(len) + 1;
      for (int i = 0; i < n; i++) begin
         w = (start + i) % DEPTH;
         for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[w][8*b +: 8] = wbuf[i][8*b +: 8];
      end
      push_ev(EV_WB, 32'h0, 1'b0);
      push_ev(EV_BR, 32'h0, 1'b0);
      @(negedge clk);
      ram_wdata  = strb;
      ram_addr_o = addr;
      ram_awlen  = len;
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!ram_wready && cnt < 20);
      check("wready", 32'(ram_wready), 32'h1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ram_wvalid = 1'b1;
         ram_data_o = wbuf[i];
         ram_wlast  = (i == wl);
         @(posedge clk);
      end
      @(negedge clk);
      ram_wvalid = 1'b0;
      ram_wlast  = 1'b0;
      wait_drain("write");
      repeat (2) @(posedge clk);
      @(negedge clk);
      ram_wdata = 4'h0;
      ram_awlen = 4'h0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int cnt;
      int wl;
      logic [3:0] len;
      vectors     = 0;
      miscompares = 0;
      rst        = 1'b0;
      ram_rdata  = 1'b0;
      ram_wdata  = 4'h0;
      ram_addr_o = 32'h0;
      ram_data_o = 32'h0;
      ram_arlen  = 4'h0;
      ram_awlen  = 4'h0;
      ram_wvalid = 1'b0;
      ram_wlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ctrl outs", {23'b0, ram_rid, ram_rvalid, ram_rlast, write_begin, ram_wready, ram_bvalid}, 32'h0);
      check("reset rdata", ram_data_i, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // fill the whole memory so every later read has a known reference
      for (int blk = 0; blk < DEPTH / 16; blk++) begin
         for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
         write_txn(32'(blk * 64), 4'hF, 4'hF, 15);
      end

      // directed: four-beat read and single-beat read
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
      write_txn(32'h40, 4'd3, 4'hF, 3);
      read_txn(32'h40, 4'd3, 4'h0);
      read_txn(32'h44, 4'd0, 4'h0);

      // directed: partial-strobe write over a known word
      wbuf[0] = 32'h1122_3344;
      write_txn(32'h80, 4'd0, 4'hF, 0);
      wbuf[0] = 32'hDEAD_BEEF;
      write_txn(32'h80, 4'd0, 4'b0011, 0);
      read_txn(32'h80, 4'd0, 4'h0);

      // directed: write and read bursts that wrap past the top index
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      write_txn(32'((DEPTH - 2) * 4), 4'd3, 4'hF, 3);
      read_txn(32'((DEPTH - 2) * 4), 4'd3, 4'h0);

      // directed: read wins over a simultaneous write, then the write goes through
      read_txn(32'h40, 4'd1, 4'hF);
      for (int i = 0; i < 2; i++) wbuf[i] = 32'h5A5A_0000 + 32'(i);
      write_txn(32'h100, 4'd1, 4'hF, 1);
      read_txn(32'h100, 4'd1, 4'h0);

      // directed: early wlast and missing wlast
      for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
      write_txn(32'h200, 4'd7, 4'hF, 2);
      read_txn(32'h200, 4'd7, 4'h0);
      for (int i = 0; i < 8; i++) wbuf[i] = 32'hFACE_0000 + 32'(i);
      write_txn(32'h240, 4'd5, 4'hF, -1);
      read_txn(32'h240, 4'd7, 4'h0);

      // directed: reset during the second beat of a read
      for (int i = 0; i < 4; i++) push_ev(EV_RD, ref_mem[16 + i], (i == 3));
      @(negedge clk);
      ram_rdata  = 1'b1;
      ram_addr_o = 32'h40;
      ram_arlen  = 4'd3;
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!ram_rvalid && cnt < 20);
      check("abort first beat", 32'(ram_rvalid), 32'h1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort ctrl outs", {23'b0, ram_rid, ram_rvalid, ram_rlast, write_begin, ram_wready, ram_bvalid}, 32'h0);
      check("abort rdata", ram_data_i, 32'h0);
      check("abort beats left", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      ram_rdata = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      read_txn(32'h40, 4'd3, 4'h0);

      // randomized mix of reads and writes
      for (int t = 0; t < 80; t++) begin
         len = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) begin
            read_txn($urandom, len, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
         end else begin
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            case ($urandom_range(0, 2))
               0:       wl = int'(len);
               1:       wl = $urandom_range(0, int'(len));
               default: wl = -1;
            endcase
            write_txn($urandom, len, 4'($urandom_range(1, 15)), wl);
         end
      end

      check("scoreboard empty", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
